mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 157 +++++++++++++++
 tb/tb_mul_div_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Multiplication is radix-2 shift-add and division is restoring shift-subtract, both on operand magnitudes.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [2:0]         op_r;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic               neg_q, neg_r;

    logic               op_ok, is_mt, is_div, sgn, a_neg, b_neg, b_zero, accept;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     add_sum, shifted, diff;
    logic [2*WIDTH-1:0] prod_step, mul_res;
    logic [WIDTH-1:0]   q_raw, r_raw, q_fix, r_fix;

    always_comb begin
        op_ok  = !(op[2] && op[1]);
        is_mt  = op[2] && !op[1];
        is_div = !op[2] && op[1];
        sgn    = !op[2] && !op[0];
        a_neg  = sgn && a[WIDTH-1];
        b_neg  = sgn && b[WIDTH-1];
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
        b_zero = (b == '0);
        accept = start && !flush && (state == IDLE || state == DONE) && op_ok;
    end

    // One iteration step; prod holds {accumulator, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        add_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mcand : '0)};
        shifted = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
        diff    = shifted - {1'b0, mcand};
        if (op_r[1]) begin
            if (diff[WIDTH])
                prod_step = {shifted[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
            else
                prod_step = {diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
        end else begin
            prod_step = {add_sum, prod[WIDTH-1:1]};
        end
    end

    always_comb begin
        mul_res = neg_q ? -prod : prod;
        q_raw   = prod[WIDTH-1:0];
        r_raw   = prod[2*WIDTH-1:WIDTH];
        q_fix   = neg_q ? -q_raw : q_raw;
        r_fix   = neg_r ? -r_raw : r_raw;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (accept)
                    state_nxt = (is_mt || (is_div && b_zero)) ? DONE : CALC;
            end
            CALC: begin
                if (flush)
                    state_nxt = IDLE;
                else if (cnt == CW'(WIDTH - 1))
                    state_nxt = FIX;
            end
            FIX:     state_nxt = flush ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            op_r        <= '0;
            mcand       <= '0;
            prod        <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        if (op == 3'b100) begin
                            hi <= a;
                        end else if (op == 3'b101) begin
                            lo <= a;
                        end else if (is_div && b_zero) begin
                            hi          <= a;
                            lo          <= '1;
                            div_by_zero <= 1'b1;
                        end else begin
                            op_r  <= op;
                            cnt   <= '0;
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= a_neg;
                            mcand <= is_div ? b_mag : a_mag;
                            prod  <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
                        end
                    end
                end
                CALC: begin
                    if (!flush) begin
                        prod <= prod_step;
                        cnt  <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    if (!flush) begin
                        div_by_zero <= 1'b0;
                        if (op_r[1]) begin
                            hi <= r_fix;
                            lo <= q_fix;
                        end else begin
                            hi <= mul_res[2*WIDTH-1:WIDTH];
                            lo <= mul_res[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == CALC) || (state == FIX);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit at WIDTH = 32: directed operations push expected HI/LO/flag/cycle,
// and a monitor pops and compares on every done pulse.
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        bit          cd;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] mhi = '0, mlo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(cyc), 64'(-1));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", 64'(cyc), 64'(e.due));
                check("hi", 64'(hi), 64'(e.hi));
                check("lo", 64'(lo), 64'(e.lo));
                if (e.cd) check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
            end
        end
    end

    // lat: edges from the accepting edge to the edge after which done is seen.
    task automatic send(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int lat, input logic [31:0] eh, input logic [31:0] el,
                        input logic ed, input bit cd);
        exp_t e;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        e.hi = eh; e.lo = el; e.dbz = ed; e.cd = cd; e.due = cyc + 1 + lat;
        sb.push_back(e);
        mhi = eh; mlo = el;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int n0;
        exp_t e;

        // Reset state
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;

        send(3'b000, 32'hFFFF_FFFD, 32'h0000_0005, 33, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b1);
        drain();
        send(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b1);
        drain();
        send(3'b011, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0, 1'b1);
        drain();

        // Divide by zero: no CALC, busy stays low
        send(3'b011, 32'h0000_0007, 32'h0000_0000, 0, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1, 1'b1);
        check("dbz_busy", 64'(busy), 64'd0);
        drain();
        check("dbz_busy_after", 64'(busy), 64'd0);

        send(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1);
        drain();
        send(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1);
        drain();
        send(3'b010, 32'h0000_0064, 32'hFFFF_FFF9, 33, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0, 1'b1);
        drain();

        // Reserved op: nothing happens
        @(negedge clk); start = 1'b1; op = 3'b110; a = 32'hDEAD_BEEF; b = 32'h1;
        @(negedge clk); start = 1'b0;
        check("rsv_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check("rsv_hi", 64'(hi), 64'(mhi));
        check("rsv_lo", 64'(lo), 64'(mlo));

        // MTLO then MTHI accepted back-to-back (second start lands in DONE)
        @(negedge clk); start = 1'b1; op = 3'b101; a = 32'hCAFE_BABE;
        e.hi = mhi; e.lo = 32'hCAFE_BABE; e.dbz = 1'b0; e.cd = 1'b0; e.due = cyc + 1;
        sb.push_back(e); mlo = 32'hCAFE_BABE;
        @(negedge clk); op = 3'b100; a = 32'h0BAD_F00D;
        check("mt_busy", 64'(busy), 64'd0);
        e.hi = 32'h0BAD_F00D; e.lo = mlo; e.due = cyc + 1;
        sb.push_back(e); mhi = 32'h0BAD_F00D;
        @(negedge clk); start = 1'b0;
        drain();

        // Flush at the 10th CALC cycle with start held high throughout
        @(negedge clk); start = 1'b1; op = 3'b001; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        n0 = cyc + 1;
        for (int k = 0; k < 20 && cyc != n0 + 9; k++) @(negedge clk);
        check("flush_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_hi", 64'(hi), 64'(mhi));
        check("flush_lo", 64'(lo), 64'(mlo));
        e.hi = 32'hFFFF_FFFE; e.lo = 32'h0000_0001; e.dbz = 1'b0; e.cd = 1'b1; e.due = cyc + 1 + 33;
        sb.push_back(e); mhi = e.hi; mlo = e.lo;
        @(negedge clk);
        check("restart_busy", 64'(busy), 64'd1);
        start = 1'b0;
        drain();

        // MTHI, then MULTU with start held while busy, then async reset mid-CALC
        send(3'b100, 32'h1234_5678, 32'h0, 0, 32'h1234_5678, mlo, 1'b0, 1'b0);
        drain();
        @(negedge clk); start = 1'b1; op = 3'b001; a = 32'h3; b = 32'h4;
        @(negedge clk);
        check("mid_busy", 64'(busy), 64'd1);
        repeat (3) @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        mhi = '0; mlo = '0;
        send(3'b101, 32'h0000_0055, 32'h0, 0, 32'h0000_0000, 32'h0000_0055, 1'b0, 1'b0);
        drain();
        repeat (45) @(negedge clk);
        check("final_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
